obstacle_scroller: RTL and testbench
====================================

// Module: obstacle_scroller
// PURPOSE
//  Upstream feeder of the obstacle display stage. Owns a single on-screen obstacle slot
//  and drives the packed word {en, type[3:0], col[9:0]}, where col is the obstacle's
//  right-edge screen column. Spawns a pseudo-random cactus or bird at the right edge,
//  scrolls it left by `speed` pixels per game tick, and retires it at the left edge.
//  After each retire it waits a random gap before the next spawn. It pulses
//  `spawned`/`passed` for the scorer and the difficulty logic.
// PARAMETERS
//  SPAWN_COL  10'd720    right-edge column loaded at spawn; off-screen right, >= 640+75
//  MIN_GAP    8'd40      minimum idle ticks between retire and next spawn
//  INIT_GAP   8'd60      idle ticks after reset before the first spawn
//  SEED       16'hACE1   LFSR reset value; must be nonzero
// PORTS
//  clk       in   1   system clock; the only clock
//  rst       in   1   synchronous, active-high reset
//  tick      in   1   game-step strobe, one clk wide; all motion is gated by it
//  run       in   1   1 = game running; 0 = freeze (game over / paused)
//  speed     in   4   pixels moved per tick; 0 = no motion
//  bird_en   in   1   1 = bird types may be spawned
//  obstacle  out  15  {en, type[3:0], col[9:0]}; registered
//  spawned   out  1   1-clk pulse on the cycle the new obstacle first appears on `obstacle`
//  passed    out  1   1-clk pulse on the cycle `obstacle` becomes disabled by retire
// BEHAVIOUR
//  Reset (rst=1 at posedge, overrides everything):
//   - obstacle=15'd0, spawned=0, passed=0, state=IDLE, gap_cnt=INIT_GAP, lfsr=SEED.
//   - Mid-operation reset drops any live obstacle immediately, with no `passed` pulse.
//  LFSR:
//   - 16-bit Fibonacci, taps 16,14,13,11; shifts left with the feedback bit into bit 0.
//   - Advances every clk cycle out of reset, regardless of tick/run.
//   - Spawn and gap decisions use the value held in the same cycle as the deciding tick.
//  Qualifying tick: tick=1 AND run=1. Otherwise state, gap_cnt and obstacle all hold.
//  spawned and passed are 0 in every cycle except those named below.
//  FSM IDLE (obstacle[14]=0), on a qualifying tick:
//   - gap_cnt!=0: gap_cnt <= gap_cnt-1.
//   - gap_cnt==0: spawn. obstacle <= {1'b1, T, SPAWN_COL}; spawned=1 next cycle;
//     go to ACTIVE.
//  FSM ACTIVE, on a qualifying tick:
//   - col > speed: col <= col-speed. en and type are unchanged.
//   - col <= speed: retire. obstacle <= 15'd0; passed=1 next cycle; go to IDLE;
//     gap_cnt <= MIN_GAP + {2'b0, lfsr[11:6]} (8-bit, max 103, no overflow).
//   - col is never written below 1 while enabled, so no wrap-around through 1023.
//   - speed=0 means col holds and the obstacle never retires.
//  Type select T from s=lfsr[2:0]:
//   - s=0..2  -> 4'd1..4'd3 (small cactus x1/x2/x3).
//   - s=3..5  -> 4'd5..4'd7 (large cactus x1/x2/x3).
//   - s=6,7 with bird_en=1 -> bird height from h=lfsr[4:3]:
//     h=0,1 -> 4'd9 (low); h=2 -> 4'd10 (mid); h=3 -> 4'd11 (high).
//   - s=6,7 with bird_en=0 -> 4'd1.
//   - Types 0, 4, 8 and 12..15 are never emitted.
//  Latency: obstacle, spawned and passed all update on the clk edge after the qualifying tick.
//  tick held high for N cycles counts as N ticks; the block does no edge detection.
//  Changes to speed or bird_en take effect on the next qualifying tick only.
// TESTING
//  1 Reset, run=1, tick every 4 clk -> obstacle==0 through 60 ticks; spawn on tick 61;
//    spawned high exactly one clk.
//  2 Force lfsr[2:0]=6, lfsr[4:3]=2, bird_en=1 at spawn -> obstacle=={1,4'd10,10'd720};
//    same with bird_en=0 -> type 4'd1.
//  3 ACTIVE at col=720, speed=7 -> col 713, 706, ...; at col=6 the next tick gives
//    obstacle=0, passed=1, gap_cnt in [40,103].
//  4 ACTIVE col=300, run=0 with 20 ticks -> col stays 300; run=1 resumes at 300-speed.
//  5 rst asserted together with tick while ACTIVE -> obstacle=0, passed=0, gap_cnt=60.
//  6 10k random ticks, random speed 1..15 -> en=1 implies type in {1,2,3,5,6,7,9,10,11}
//    and 1<=col<=720; spawned count == passed count (+1 if ACTIVE).

Source files
------------

// File: rtl/obstacle_scroller.sv
// Obstacle scroller: owns one on-screen obstacle slot. Spawns a pseudo-random cactus or
// bird at the right edge, scrolls it left by `speed` pixels per qualifying tick, retires it
// at the left edge, then idles for a random gap before the next spawn.
module obstacle_scroller #(
    parameter logic [9:0]  SPAWN_COL = 10'd720,
    parameter logic [7:0]  MIN_GAP   = 8'd40,
    parameter logic [7:0]  INIT_GAP  = 8'd60,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        run,
    input  logic [3:0]  speed,
    input  logic        bird_en,
    output logic [14:0] obstacle,
    output logic        spawned,
    output logic        passed
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e      state_q, state_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        obs_en_q, obs_en_d;
    logic [3:0]  obs_type_q, obs_type_d;
    logic [9:0]  obs_col_q, obs_col_d;
    logic        spawned_q, spawned_d;
    logic        passed_q, passed_d;

    logic        qual_tick;
    logic        lfsr_fb;
    logic [3:0]  spawn_type;
    logic [9:0]  speed_ext;

    assign qual_tick = tick & run;
    assign speed_ext = {6'd0, speed};

    // Free-running LFSR, taps 16,14,13,11; advances every cycle independent of tick/run.
    always_comb begin
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
    end

    // Obstacle type chosen from the LFSR value held in the deciding cycle.
    always_comb begin
        spawn_type = 4'd1;
        case (lfsr_q[2:0])
            3'd0: spawn_type = 4'd1;
            3'd1: spawn_type = 4'd2;
            3'd2: spawn_type = 4'd3;
            3'd3: spawn_type = 4'd5;
            3'd4: spawn_type = 4'd6;
            3'd5: spawn_type = 4'd7;
            default: begin
                if (!bird_en) begin
                    spawn_type = 4'd1;
                end else begin
                    case (lfsr_q[4:3])
                        2'd2:    spawn_type = 4'd10;
                        2'd3:    spawn_type = 4'd11;
                        default: spawn_type = 4'd9;
                    endcase
                end
            end
        endcase
    end

    // Next-state logic: spawn / scroll / retire, all gated by a qualifying tick.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        obs_en_d   = obs_en_q;
        obs_type_d = obs_type_q;
        obs_col_d  = obs_col_q;
        spawned_d  = 1'b0;
        passed_d   = 1'b0;
        if (qual_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (gap_q != 8'd0) begin
                        gap_d = gap_q - 8'd1;
                    end else begin
                        obs_en_d   = 1'b1;
                        obs_type_d = spawn_type;
                        obs_col_d  = SPAWN_COL;
                        spawned_d  = 1'b1;
                        state_d    = StActive;
                    end
                end
                StActive: begin
                    if (obs_col_q > speed_ext) begin
                        obs_col_d = obs_col_q - speed_ext;
                    end else if (speed != 4'd0) begin
                        // Retire rather than wrap below column 1.
                        obs_en_d   = 1'b0;
                        obs_type_d = 4'd0;
                        obs_col_d  = 10'd0;
                        passed_d   = 1'b1;
                        state_d    = StIdle;
                        gap_d      = MIN_GAP + {2'b00, lfsr_q[11:6]};
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State register with synchronous reset; reset drops a live obstacle silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gap_q      <= INIT_GAP;
            lfsr_q     <= SEED;
            obs_en_q   <= 1'b0;
            obs_type_q <= 4'd0;
            obs_col_q  <= 10'd0;
            spawned_q  <= 1'b0;
            passed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            lfsr_q     <= lfsr_d;
            obs_en_q   <= obs_en_d;
            obs_type_q <= obs_type_d;
            obs_col_q  <= obs_col_d;
            spawned_q  <= spawned_d;
            passed_q   <= passed_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        obstacle = {obs_en_q, obs_type_q, obs_col_q};
        spawned  = spawned_q;
        passed   = passed_q;
    end

endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed + randomised bench for obstacle_scroller.
module tb_obstacle_scroller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        run = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic        bird_en = 1'b0;
    logic [14:0] obstacle;
    logic        spawned;
    logic        passed;

    int total = 0;
    int bad = 0;

    // Bench-side LFSR reference, tracks the value the DUT holds in each cycle.
    logic [15:0] m_lfsr = 16'h0000;

    obstacle_scroller dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .run      (run),
        .speed    (speed),
        .bird_en  (bird_en),
        .obstacle (obstacle),
        .spawned  (spawned),
        .passed   (passed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [3:0] exp_type(input logic [15:0] l, input logic be);
        logic [3:0] t;
        case (l[2:0])
            3'd0: t = 4'd1;
            3'd1: t = 4'd2;
            3'd2: t = 4'd3;
            3'd3: t = 4'd5;
            3'd4: t = 4'd6;
            3'd5: t = 4'd7;
            default: begin
                if (!be)                t = 4'd1;
                else if (l[4:3] == 2'd2) t = 4'd10;
                else if (l[4:3] == 2'd3) t = 4'd11;
                else                     t = 4'd9;
            end
        endcase
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; run = 1'b0; speed = 4'd0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (obstacle !== 15'd0) begin
            bad++; $display("FAIL reset_obstacle: got %h want %h", obstacle, 15'd0);
        end
        total++;
        if (spawned !== 1'b0 || passed !== 1'b0) begin
            bad++; $display("FAIL reset_pulses: got spawned=%b passed=%b want 0 0", spawned, passed);
        end
        run = 1'b1;
        repeat (5) step();
        total++;
        if (obstacle !== 15'd0) begin
            bad++; $display("FAIL no_tick_hold: got %h want %h", obstacle, 15'd0);
        end
    endtask

    task automatic test_first_spawn();
        logic [3:0] t;
        do_reset();
        run = 1'b1; bird_en = 1'b1; speed = 4'd0;
        for (int i = 1; i <= 60; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
            total++;
            if (obstacle !== 15'd0 || spawned !== 1'b0) begin
                bad++; $display("FAIL gap_tick%0d: got obs=%h spawned=%b want 0 0", i, obstacle, spawned);
            end
            repeat (3) step();
        end
        t = exp_type(m_lfsr, bird_en);
        tick = 1'b1; step(); tick = 1'b0;
        total++;
        if (obstacle !== {1'b1, t, 10'd720}) begin
            bad++; $display("FAIL first_spawn: got %h want %h", obstacle, {1'b1, t, 10'd720});
        end
        total++;
        if (spawned !== 1'b1) begin
            bad++; $display("FAIL spawned_pulse: got %b want 1", spawned);
        end
        step();
        total++;
        if (spawned !== 1'b0) begin
            bad++; $display("FAIL spawned_width: got %b want 0", spawned);
        end
    endtask

    // Reset, drain the initial gap, then wait for an LFSR pattern and spawn on it.
    task automatic spawn_when(input logic [4:0] mask, input logic [4:0] pat, input logic be,
                              input logic [3:0] exp_t, input string name);
        int n;
        do_reset();
        run = 1'b1; bird_en = be; speed = 4'd0;
        tick = 1'b1;
        repeat (60) step();
        tick = 1'b0;
        n = 0;
        while (((m_lfsr[4:0] & mask) != pat) && n < 2000) begin
            step(); n++;
        end
        total++;
        if (n >= 2000) begin
            bad++; $display("FAIL %s_timeout: got no pattern want pattern %b", name, pat);
        end else begin
            tick = 1'b1; step(); tick = 1'b0;
            if (obstacle !== {1'b1, exp_t, 10'd720}) begin
                bad++; $display("FAIL %s: got %h want %h", name, obstacle, {1'b1, exp_t, 10'd720});
            end
        end
    endtask

    task automatic test_type_select();
        spawn_when(5'b11111, 5'b10110, 1'b1, 4'd10, "bird_mid");
        spawn_when(5'b00111, 5'b00110, 1'b0, 4'd1,  "bird_off");
        spawn_when(5'b11111, 5'b11111, 1'b1, 4'd11, "bird_high");
        spawn_when(5'b11111, 5'b00111, 1'b1, 4'd9,  "bird_low");
        spawn_when(5'b00111, 5'b00100, 1'b1, 4'd6,  "large_x2");
        spawn_when(5'b00111, 5'b00010, 1'b1, 4'd3,  "small_x3");
    endtask

    task automatic test_scroll_retire();
        int gap;
        int ok;
        spawn_when(5'b00111, 5'b00000, 1'b1, 4'd1, "small_x1");
        speed = 4'd7;
        tick = 1'b1;
        ok = 1;
        for (int k = 1; k <= 102; k++) begin
            step();
            if (ok == 1 && (obstacle !== {1'b1, 4'd1, 10'(720 - 7 * k)} || passed !== 1'b0)) begin
                $display("FAIL scroll_k%0d: got %h want %h", k, obstacle, {1'b1, 4'd1, 10'(720 - 7 * k)});
                ok = 0;
            end
        end
        total++;
        if (ok == 0) bad++;
        gap = 40 + int'(m_lfsr[11:6]);
        step();
        tick = 1'b0;
        total++;
        if (obstacle !== 15'd0 || passed !== 1'b1) begin
            bad++; $display("FAIL retire: got obs=%h passed=%b want 0 1", obstacle, passed);
        end
        step();
        total++;
        if (passed !== 1'b0) begin
            bad++; $display("FAIL passed_width: got %b want 0", passed);
        end
        ok = 1;
        for (int g = 1; g <= gap; g++) begin
            tick = 1'b1; step(); tick = 1'b0;
            if (ok == 1 && obstacle !== 15'd0) begin
                $display("FAIL retire_gap%0d: got %h want 0 (gap %0d)", g, obstacle, gap);
                ok = 0;
            end
        end
        total++;
        if (ok == 0) bad++;
        tick = 1'b1; step(); tick = 1'b0;
        total++;
        if (obstacle[14] !== 1'b1 || spawned !== 1'b1 || obstacle[9:0] !== 10'd720) begin
            bad++; $display("FAIL respawn_after_gap: got obs=%h spawned=%b want en=1 col=720 spawned=1",
                            obstacle, spawned);
        end
    endtask

    task automatic test_freeze();
        spawn_when(5'b00111, 5'b00000, 1'b1, 4'd1, "freeze_spawn");
        speed = 4'd7;
        tick = 1'b1;
        repeat (60) step();
        tick = 1'b0;
        total++;
        if (obstacle !== {1'b1, 4'd1, 10'd300}) begin
            bad++; $display("FAIL at_300: got %h want %h", obstacle, {1'b1, 4'd1, 10'd300});
        end
        run = 1'b0; tick = 1'b1;
        repeat (20) step();
        total++;
        if (obstacle !== {1'b1, 4'd1, 10'd300}) begin
            bad++; $display("FAIL freeze: got %h want %h", obstacle, {1'b1, 4'd1, 10'd300});
        end
        run = 1'b1;
        step();
        tick = 1'b0;
        total++;
        if (obstacle !== {1'b1, 4'd1, 10'd293}) begin
            bad++; $display("FAIL resume: got %h want %h", obstacle, {1'b1, 4'd1, 10'd293});
        end
        speed = 4'd0; tick = 1'b1;
        repeat (5) step();
        tick = 1'b0;
        total++;
        if (obstacle !== {1'b1, 4'd1, 10'd293} || passed !== 1'b0) begin
            bad++; $display("FAIL speed0_hold: got %h passed=%b want %h 0", obstacle, passed,
                            {1'b1, 4'd1, 10'd293});
        end
    endtask

    task automatic test_reset_active();
        logic [3:0] t;
        int ok;
        spawn_when(5'b00111, 5'b00011, 1'b1, 4'd5, "large_x1");
        speed = 4'd9; tick = 1'b1;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0; tick = 1'b0;
        total++;
        if (obstacle !== 15'd0 || passed !== 1'b0 || spawned !== 1'b0) begin
            bad++; $display("FAIL rst_active: got obs=%h passed=%b spawned=%b want 0 0 0",
                            obstacle, passed, spawned);
        end
        step();
        total++;
        if (passed !== 1'b0) begin
            bad++; $display("FAIL rst_no_passed: got %b want 0", passed);
        end
        tick = 1'b1; ok = 1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (ok == 1 && obstacle !== 15'd0) begin
                $display("FAIL rst_gap%0d: got %h want 0", i, obstacle); ok = 0;
            end
        end
        total++;
        if (ok == 0) bad++;
        t = exp_type(m_lfsr, bird_en);
        step();
        tick = 1'b0;
        total++;
        if (obstacle !== {1'b1, t, 10'd720} || spawned !== 1'b1) begin
            bad++; $display("FAIL rst_respawn: got %h spawned=%b want %h 1", obstacle, spawned,
                            {1'b1, t, 10'd720});
        end
    endtask

    task automatic test_random();
        int sp_cnt;
        int pa_cnt;
        int inv_bad;
        logic [15:0] pre_l;
        logic pre_be;
        logic [3:0] ty;
        do_reset();
        sp_cnt = 0; pa_cnt = 0; inv_bad = 0;
        for (int c = 0; c < 20000; c++) begin
            tick = 1'($urandom_range(0, 1));
            speed = 4'($urandom_range(1, 15));
            bird_en = 1'($urandom_range(0, 1));
            run = ($urandom_range(0, 15) != 0);
            pre_l = m_lfsr; pre_be = bird_en;
            step();
            ty = obstacle[13:10];
            if (obstacle[14]) begin
                if (!(ty inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11}) ||
                    obstacle[9:0] < 10'd1 || obstacle[9:0] > 10'd720) begin
                    if (inv_bad < 5) $display("FAIL rand_range c%0d: got %h want legal type, col 1..720", c, obstacle);
                    inv_bad++;
                end
            end
            if (spawned) begin
                sp_cnt++;
                if (ty !== exp_type(pre_l, pre_be) || obstacle[9:0] !== 10'd720) begin
                    if (inv_bad < 5) $display("FAIL rand_spawn c%0d: got %h want type %h col 720",
                                              c, obstacle, exp_type(pre_l, pre_be));
                    inv_bad++;
                end
            end
            if (passed) begin
                pa_cnt++;
                if (obstacle !== 15'd0) begin
                    if (inv_bad < 5) $display("FAIL rand_passed c%0d: got %h want 0", c, obstacle);
                    inv_bad++;
                end
            end
        end
        tick = 1'b0;
        total++;
        if (inv_bad != 0) begin
            bad++; $display("FAIL rand_invariants: got %0d violations want 0", inv_bad);
        end
        total++;
        if (sp_cnt != pa_cnt + int'(obstacle[14])) begin
            bad++; $display("FAIL rand_counts: got spawned=%0d passed=%0d en=%b want balanced",
                            sp_cnt, pa_cnt, obstacle[14]);
        end
        total++;
        if (sp_cnt < 5) begin
            bad++; $display("FAIL rand_activity: got %0d spawns want >= 5", sp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_type_select();
        test_scroll_retire();
        test_freeze();
        test_reset_active();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
